// File: rtl/sseg_scan_capture_if.sv
// Bundle of the multiplexed seven-segment pins and the captured display data.
// The master side drives the scanned pins; the slave side is the capture block.
interface sseg_scan_capture_if;
   logic [7:0]  sseg;
   logic [5:0]  en;
   logic [23:0] digit_val;
   logic [5:0]  digit_vld;
   logic [5:0]  dp;
   logic        frame_strobe;
   logic        code_err;
   logic        en_err;
   logic        stale;

   modport master (
      output sseg, en,
      input  digit_val, digit_vld, dp, frame_strobe, code_err, en_err, stale
   );

   modport slave (
      input  sseg, en,
      output digit_val, digit_vld, dp, frame_strobe, code_err, en_err, stale
   );
endinterface

// File: rtl/sseg_scan_capture.sv
// Sniffs a scanned 6-digit, active-low seven-segment display and rebuilds the
// displayed BCD digits and decimal points.  The pin word is synchronized,
// must sit unchanged for STABLE_CYCLES samples, and is then decoded exactly
// once into the digit selected by the single low enable.
module sseg_scan_capture #(
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input logic              clk,
   input logic              rst,
   sseg_scan_capture_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   // The evaluation fires on the edge where the stability count would
   // reach STABLE_CYCLES-1, so the register is compared one count early.
   localparam logic [7:0]  EVAL_CNT    = 8'(STABLE_CYCLES - 2);
   localparam logic [23:0] TIMEOUT_VAL = 24'(TIMEOUT_CYCLES);

   logic [13:0] sync1_reg, sync2_reg;
   logic [13:0] w;
   logic [13:0] w_prev_reg;
   logic [5:0]  w_en;
   logic [7:0]  w_seg;

   state_t      state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic        w_change;
   logic        eval;

   logic [5:0]  en_low;
   logic        en_any, en_multi, en_onehot;
   logic [3:0]  dec_val;
   logic        dec_legal;
   logic        capture, bad_code, bad_en;

   logic [23:0] digit_val_reg;
   logic [5:0]  digit_vld_reg;
   logic [5:0]  dp_reg;
   logic [5:0]  seen_reg;
   logic        frame_strobe_reg;
   logic        code_err_reg;
   logic        en_err_reg;
   logic        stale_reg;
   logic [23:0] tcnt_reg;
   logic        frame_due;
   logic        timeout_hit;
   logic [5:0]  seen_base;

   assign w     = sync2_reg;
   assign w_en  = w[13:8];
   assign w_seg = w[7:0];

   // Two-flop synchronizer for the asynchronous pin word {en, sseg}.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= '1;
         sync2_reg <= '1;
      end else begin
         sync1_reg <= {bus.en, bus.sseg};
         sync2_reg <= sync1_reg;
      end
   end

   // Settle FSM state, stability counter and previous-cycle copy of W.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         w_prev_reg <= '1;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         w_prev_reg <= w;
      end
   end

   // Next-state logic: any change restarts settling; a full settle interval
   // evaluates once and parks in HOLD (or IDLE) until W changes again.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      eval       = 1'b0;
      w_change   = (w != w_prev_reg);
      if (w_change) begin
         state_next = SETTLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            SETTLE: begin
               if (cnt_reg == EVAL_CNT) begin
                  eval       = 1'b1;
                  state_next = en_onehot ? HOLD : IDLE;
               end else begin
                  cnt_next = cnt_reg + 8'd1;
               end
            end
            IDLE:    state_next = IDLE;
            HOLD:    state_next = HOLD;
            default: state_next = IDLE;
         endcase
      end
   end

   // Classify the enable pattern: none, exactly one, or several digits low.
   always_comb begin
      en_low    = ~w_en;
      en_any    = |en_low;
      en_multi  = |(en_low & (en_low - 6'd1));
      en_onehot = en_any & ~en_multi;
   end

   // Active-low segment pattern to BCD; anything outside the table is illegal.
   always_comb begin
      dec_val   = 4'hF;
      dec_legal = 1'b1;
      case (w_seg[6:0])
         7'b1000000: dec_val = 4'd0;
         7'b1111001: dec_val = 4'd1;
         7'b0100100: dec_val = 4'd2;
         7'b0110000: dec_val = 4'd3;
         7'b0011001: dec_val = 4'd4;
         7'b0010010: dec_val = 4'd5;
         7'b0000010: dec_val = 4'd6;
         7'b1111000: dec_val = 4'd7;
         7'b0000000: dec_val = 4'd8;
         7'b0010000: dec_val = 4'd9;
         7'b1111111: dec_val = 4'hF;
         default:    dec_legal = 1'b0;
      endcase
   end

   // Evaluation outcomes and frame/timeout bookkeeping terms.
   always_comb begin
      capture     = eval & en_onehot & dec_legal;
      bad_code    = eval & en_onehot & ~dec_legal;
      bad_en      = eval & en_multi;
      frame_due   = (seen_reg == 6'h3F);
      seen_base   = frame_due ? 6'h00 : seen_reg;
      timeout_hit = ~capture & (tcnt_reg != TIMEOUT_VAL)
                    & (tcnt_reg == TIMEOUT_VAL - 24'd1);
   end

   // Per-digit captured value, valid flag and decimal point.
   always_ff @(posedge clk) begin
      if (rst) begin
         digit_val_reg <= 24'hFFFFFF;
         digit_vld_reg <= '0;
         dp_reg        <= '0;
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (capture && en_low[i]) begin
               digit_val_reg[i*4 +: 4] <= dec_val;
               digit_vld_reg[i]        <= 1'b1;
               dp_reg[i]               <= ~w_seg[7];
            end else if (bad_code && en_low[i]) begin
               digit_vld_reg[i] <= 1'b0;
            end else if (timeout_hit) begin
               digit_vld_reg[i] <= 1'b0;
            end
         end
      end
   end

   // Frame tracking, error pulses and the staleness timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         seen_reg         <= '0;
         frame_strobe_reg <= 1'b0;
         code_err_reg     <= 1'b0;
         en_err_reg       <= 1'b0;
         stale_reg        <= 1'b0;
         tcnt_reg         <= '0;
      end else begin
         frame_strobe_reg <= frame_due;
         code_err_reg     <= bad_code;
         en_err_reg       <= bad_en;
         if (timeout_hit) begin
            seen_reg <= '0;
         end else begin
            seen_reg <= seen_base | (capture ? en_low : 6'h00);
         end
         if (capture) begin
            tcnt_reg  <= '0;
            stale_reg <= 1'b0;
         end else if (tcnt_reg != TIMEOUT_VAL) begin
            tcnt_reg <= tcnt_reg + 24'd1;
            if (timeout_hit) begin
               stale_reg <= 1'b1;
            end
         end
      end
   end

   assign bus.digit_val    = digit_val_reg;
   assign bus.digit_vld    = digit_vld_reg;
   assign bus.dp           = dp_reg;
   assign bus.frame_strobe = frame_strobe_reg;
   assign bus.code_err     = code_err_reg;
   assign bus.en_err       = en_err_reg;
   assign bus.stale        = stale_reg;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Bench for sseg_scan_capture: directed scenarios plus random scans, with every
// cycle compared against a run-length based reference model.
module tb_sseg_scan_capture;

   localparam int STABLE = 4;
   localparam int TMO    = 100;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sseg_scan_capture_if bus ();

   sseg_scan_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec  = 0;
   int n_miss = 0;
   int n_txn  = 0;
   int strobe_cnt = 0;
   int cerr_cnt   = 0;
   int eerr_cnt   = 0;

   // Count one comparison and report it if it disagrees.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Active-low segment glyph for digits 0..9; 10 stands for blank.
   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // ---------------- reference model ----------------
   logic [13:0] s1m, s2m, wlast, w_m;
   int          run;
   logic [23:0] m_val;
   logic [5:0]  m_vld, m_dp, m_seen;
   logic        m_strobe, m_cerr, m_eerr, m_stale, legal;
   int          m_tcnt, lows, idx, d;

   // The DUT sees each pin word two edges late; a word is decoded once, on
   // the edge where it has been seen for exactly STABLE consecutive cycles.
   always @(posedge clk) begin
      if (rst) begin
         s1m = '1; s2m = '1; wlast = '1; run = STABLE + 1;
         m_val = 24'hFFFFFF; m_vld = '0; m_dp = '0; m_seen = '0;
         m_strobe = 0; m_cerr = 0; m_eerr = 0; m_stale = 0; m_tcnt = 0;
      end else begin
         w_m = s2m;
         if (w_m != wlast) run = 1;
         else if (run <= STABLE) run++;
         wlast = w_m;
         s2m = s1m;
         s1m = {bus.en, bus.sseg};

         m_strobe = (m_seen == 6'h3F);
         if (m_strobe) m_seen = '0;
         m_cerr = 0; m_eerr = 0; legal = 0;
         if (run == STABLE) begin
            lows = 0; idx = 0;
            for (int i = 0; i < 6; i++) if (!w_m[8+i]) begin lows++; idx = i; end
            if (lows >= 2) m_eerr = 1;
            else if (lows == 1) begin
               d = -1;
               for (int k = 0; k <= 10; k++) if (w_m[6:0] == glyph(k)) d = k;
               if (d >= 0) begin
                  m_val[idx*4 +: 4] = (d == 10) ? 4'hF : 4'(d);
                  m_vld[idx] = 1'b1;
                  m_dp[idx]  = ~w_m[7];
                  m_seen[idx] = 1'b1;
                  legal = 1;
               end else begin
                  m_cerr = 1;
                  m_vld[idx] = 1'b0;
               end
            end
         end
         if (legal) begin
            m_tcnt = 0; m_stale = 0;
         end else if (m_tcnt < TMO) begin
            m_tcnt++;
            if (m_tcnt == TMO) begin m_stale = 1; m_vld = '0; m_seen = '0; end
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("digit_val", 32'(bus.digit_val), 32'(m_val));
      check("digit_vld", 32'(bus.digit_vld), 32'(m_vld));
      check("dp", 32'(bus.dp), 32'(m_dp));
      check("frame_strobe", 32'(bus.frame_strobe), 32'(m_strobe));
      check("code_err", 32'(bus.code_err), 32'(m_cerr));
      check("en_err", 32'(bus.en_err), 32'(m_eerr));
      check("stale", 32'(bus.stale), 32'(m_stale));
      check("err_excl", 32'(bus.code_err & bus.en_err), 32'd0);
      if (bus.frame_strobe) strobe_cnt++;
      if (bus.code_err) cerr_cnt++;
      if (bus.en_err) eerr_cnt++;
   end

   // Apply one pin word and hold it for n cycles.
   task automatic drive(input logic [5:0] e, input logic [7:0] s, input int n);
      n_txn++;
      $display("txn %0d: en=%b sseg=%b hold=%0d", n_txn, e, s, n);
      bus.en   = e;
      bus.sseg = s;
      repeat (n) @(negedge clk);
   endtask

   logic [23:0] saved_val;
   logic [5:0]  r_en;
   logic [7:0]  r_seg;
   logic [5:0]  scan_en;

   initial begin
      rst = 1'b1;
      bus.en = '1;
      bus.sseg = '1;
      repeat (3) @(negedge clk);
      check("rst_val", 32'(bus.digit_val), 32'hFFFFFF);
      check("rst_vld", 32'(bus.digit_vld), 32'd0);
      rst = 1'b0;

      // Single legal capture of '2' on digit 0.
      drive(6'b111110, 8'b10100100, 10);
      check("d0_val", 32'(bus.digit_val[3:0]), 32'd2);
      check("d0_vld", 32'(bus.digit_vld[0]), 32'd1);
      check("d0_dp", 32'(bus.dp[0]), 32'd0);

      // Full scan 1..6 with the decimal point on digit 3.
      strobe_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         scan_en = ~(6'b1 << i);
         drive(scan_en, {(i == 3) ? 1'b0 : 1'b1, glyph(i + 1)}, 8);
      end
      drive(6'b111111, 8'hFF, 4);
      check("scan_strobes", 32'(strobe_cnt), 32'd1);
      check("scan_val", 32'(bus.digit_val), 32'h654321);
      check("scan_dp", 32'(bus.dp), 32'b001000);

      // Two enables low: one en_err, no digit change; then a glitching bus.
      eerr_cnt = 0; cerr_cnt = 0;
      saved_val = bus.digit_val;
      drive(6'b111100, 8'hF9, 10);
      check("multi_en_err", 32'(eerr_cnt), 32'd1);
      check("multi_en_val", 32'(bus.digit_val), 32'(saved_val));
      eerr_cnt = 0;
      for (int i = 0; i < 6; i++) drive(6'b111101, (i % 2 == 0) ? 8'hA4 : 8'hB0, 3);
      drive(6'b111111, 8'hFF, 8);
      check("glitch_val", 32'(bus.digit_val), 32'(saved_val));
      check("glitch_errs", 32'(eerr_cnt + cerr_cnt), 32'd0);

      // Blank then an illegal pattern on digit 2.
      drive(6'b111011, 8'hFF, 10);
      check("blank_val", 32'(bus.digit_val[11:8]), 32'hF);
      check("blank_vld", 32'(bus.digit_vld[2]), 32'd1);
      cerr_cnt = 0;
      drive(6'b111011, 8'hAA, 10);
      check("bad_code_cnt", 32'(cerr_cnt), 32'd1);
      check("bad_code_vld", 32'(bus.digit_vld[2]), 32'd0);
      check("bad_code_val", 32'(bus.digit_val[11:8]), 32'hF);

      // Staleness after a long idle, cleared by the next capture.
      drive(6'b111110, 8'hC0, 10);
      drive(6'b111111, 8'hFF, 120);
      check("stale_set", 32'(bus.stale), 32'd1);
      check("stale_vld", 32'(bus.digit_vld), 32'd0);
      drive(6'b111110, 8'hF9, 10);
      check("stale_clr", 32'(bus.stale), 32'd0);

      // Reset in the middle of settling discards the pending capture.
      drive(6'b111110, 8'hB0, 4);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("mid_rst_val", 32'(bus.digit_val), 32'hFFFFFF);
      repeat (5) @(negedge clk);
      check("post_rst_wait", 32'(bus.digit_val[3:0]), 32'hF);
      @(negedge clk);
      check("post_rst_cap", 32'(bus.digit_val[3:0]), 32'd3);

      // Random scanning traffic.
      for (int t = 0; t < 80; t++) begin
         case ($urandom_range(0, 9))
            0, 1:    r_en = 6'b111111;
            2:       r_en = 6'($urandom);
            default: r_en = ~(6'b1 << $urandom_range(0, 5));
         endcase
         if ($urandom_range(0, 9) < 7) r_seg = {1'($urandom), glyph($urandom_range(0, 10))};
         else r_seg = 8'($urandom);
         drive(r_en, r_seg, $urandom_range(1, 10));
      end
      drive(6'b111111, 8'hFF, 110);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
